// File: rtl/demux_1a2.sv
// -----------------------------------------------------------------------------
// demux_1a2 : byte-interleaved 1:2 demultiplexer (receive side of the 2-lane PHY)
//
// Splits the single fast-clock stream from the 2:1 mux back into two lanes.
// Even slots carry lane 0 and odd slots carry lane 1. Everything runs on the
// rising edge of clk2f.
//
// Ports
//   clk2f        in   fast clock (2x lane rate)
//   reset        in   synchronous, active-high reset
//   data_in      in   [BW-1:0] interleaved data
//   valid_in     in   qualifies data_in for the current slot
//   data_out_0   out  [BW-1:0] lane 0 data, held while no new valid byte arrives
//   valid_out_0  out  lane 0 valid
//   data_out_1   out  [BW-1:0] lane 1 data, held while no new valid byte arrives
//   valid_out_1  out  lane 1 valid
//   lane_sel     out  owner of the current slot (0 = lane 0, 1 = lane 1)
//   pair_strobe  out  one-cycle pulse after each completed lane-0/lane-1 pair
//
// Build option
//   DEMUX_ALIGN_OUT_EN  When defined, lane 0 is parked in a holding register
//                       on its slot edge. Both lanes then update together on
//                       the odd-slot edge. When undefined, each lane updates
//                       on its own slot edge and no holding register exists.
// -----------------------------------------------------------------------------
module demux_1a2 #(
    parameter int BW = 8
) (
    input  logic          clk2f,
    input  logic          reset,
    input  logic [BW-1:0] data_in,
    input  logic          valid_in,
    output logic [BW-1:0] data_out_0,
    output logic          valid_out_0,
    output logic [BW-1:0] data_out_1,
    output logic          valid_out_1,
    output logic          lane_sel,
    output logic          pair_strobe
);

    // Slot tracking. The value seen during a cycle names the slot whose byte
    // is sampled at the end of that cycle.
    logic lane_sel_reg;
    logic pair_strobe_reg;

    always_ff @(posedge clk2f) begin
        if (reset) begin
            lane_sel_reg    <= 1'b0;
            pair_strobe_reg <= 1'b0;
        end else begin
            lane_sel_reg    <= ~lane_sel_reg;
            // The pulse follows every odd-slot edge, whatever the valids were.
            pair_strobe_reg <= lane_sel_reg;
        end
    end

    // Per-lane source selection: the byte/valid each lane register takes
    // and the edge on which it takes it.
    logic [BW-1:0] src_data  [2];
    logic          src_valid [2];
    logic          load      [2];

`ifdef DEMUX_ALIGN_OUT_EN
    // Lane 0 parks here on the even slot. The valid is kept with the byte so
    // the hold-if-invalid rule can still be applied on the odd-slot edge.
    logic [BW-1:0] hold_data_reg;
    logic          hold_valid_reg;

    always_ff @(posedge clk2f) begin
        if (reset) begin
            hold_data_reg  <= '0;
            hold_valid_reg <= 1'b0;
        end else if (!lane_sel_reg) begin
            hold_valid_reg <= valid_in;
            if (valid_in) begin
                hold_data_reg <= data_in;
            end
        end
    end

    always_comb begin
        src_data[0]  = hold_data_reg;
        src_valid[0] = hold_valid_reg;
        load[0]      = lane_sel_reg;
        src_data[1]  = data_in;
        src_valid[1] = valid_in;
        load[1]      = lane_sel_reg;
    end
`else
    always_comb begin
        src_data[0]  = data_in;
        src_valid[0] = valid_in;
        load[0]      = ~lane_sel_reg;
        src_data[1]  = data_in;
        src_valid[1] = valid_in;
        load[1]      = lane_sel_reg;
    end
`endif

    // Lane output registers. On a load edge the valid follows the source.
    // The data only moves when that source is valid, so an invalid byte
    // leaves the previous byte in place.
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic [BW-1:0] data_reg;
        logic          valid_reg;

        always_ff @(posedge clk2f) begin
            if (reset) begin
                data_reg  <= '0;
                valid_reg <= 1'b0;
            end else if (load[gi]) begin
                valid_reg <= src_valid[gi];
                if (src_valid[gi]) begin
                    data_reg <= src_data[gi];
                end
            end
        end
    end

    assign data_out_0  = g_lane[0].data_reg;
    assign valid_out_0 = g_lane[0].valid_reg;
    assign data_out_1  = g_lane[1].data_reg;
    assign valid_out_1 = g_lane[1].valid_reg;
    assign lane_sel    = lane_sel_reg;
    assign pair_strobe = pair_strobe_reg;

endmodule
